// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding and
// default widths/constants used by the fetch datapath.
package if_fetch_stage_pkg;

   localparam int          FETCH_PC_W      = 10;
   localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the word-addressed PC, issues one instruction
// memory request at a time and presents the fetched word to the IF/ID register.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int              PC_W      = FETCH_PC_W,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = FETCH_NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   output logic [PC_W-1:0] pc_plus_1,
   output logic            instr_valid
);

   fetch_state_t    state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_inc;
   logic            drop;

   // PC arithmetic wraps naturally at 2^PC_W.
   assign pc_inc    = pc + PC_W'(1);
   assign imem_req  = (state == S_REQ);
   assign imem_addr = pc;

   // A redirect leaves at most one response in flight; drop marks it as stale so
   // the WAIT state discards it instead of capturing a wrong-path instruction.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_RESET;
         pc          <= RESET_PC;
         instr       <= NOP_INSTR;
         pc_plus_1   <= '0;
         instr_valid <= 1'b0;
         drop        <= 1'b0;
      end else if (state == S_RESET) begin
         state <= S_REQ;
      end else if (redirect) begin
         pc          <= redirect_pc;
         instr_valid <= 1'b0;
         case (state)
            S_REQ: begin
               state <= S_WAIT;
               drop  <= 1'b1;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state <= S_REQ;
                  drop  <= 1'b0;
               end else begin
                  drop  <= 1'b1;
               end
            end
            default: state <= S_REQ;
         endcase
      end else begin
         case (state)
            S_REQ: state <= S_WAIT;
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= S_REQ;
                  end else begin
                     instr       <= imem_rdata;
                     pc_plus_1   <= pc_inc;
                     instr_valid <= 1'b1;
                     state       <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (instr_valid && !stall) begin
                  pc          <= pc_inc;
                  instr_valid <= 1'b0;
                  state       <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule
